// File: rtl/delaymc_pkg.sv
// delaymc shared types.
// Path selector for the delayed output mux.
package delaymc_pkg;

  typedef enum logic [1:0] {
    DP_LIVE = 2'd0,
    DP_REG  = 2'd1,
    DP_MEM  = 2'd2
  } dpath_e;

endpackage

// File: rtl/delaymc_sdpram_w.sv
// Simple dual-port RAM with registered read.
// No reset so synthesis can map it to block RAM.
module sdpram_w #(
  parameter int AW = 4,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we)
      mem[i_waddr] <= i_wdata;
    if (i_re)
      rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/delaymc.sv
// Multi-lane programmable delay line sharing one
// pointer pair and one wide RAM across all lanes.
module delaymc
  import delaymc_pkg::*;
#(
  parameter int LGDLY         = 4,
  parameter int DW            = 12,
  parameter int NCH           = 2,
  parameter int FIXED_DELAY   = 0,
  parameter int OPT_ZERO_FILL = 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [LGDLY-1:0]    i_delay,
  input  logic                i_ce,
  input  logic [NCH*DW-1:0]   i_word,
  output logic [NCH*DW-1:0]   o_word,
  output logic [NCH*DW-1:0]   o_delayed,
  output logic                o_primed
);

  localparam int W  = NCH * DW;
  localparam int CW = LGDLY + 1;
  localparam logic [CW-1:0] CNT_MAX =
    {1'b1, {LGDLY{1'b0}}};

  logic [LGDLY-1:0] dly;
  logic             restart;
  dpath_e           path;

  logic [LGDLY-1:0] wraddr_q, wraddr_d;
  logic [LGDLY-1:0] rdaddr_q, rdaddr_d;
  logic [LGDLY-1:0] r_delay_q, r_delay_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     word_q, word_d;
  logic [W-1:0]     delayed_q, delayed_d;
  logic             primed_q, primed_d;
  logic [W-1:0]     rd_data;
  logic [W-1:0]     sel_data;

  assign dly = (FIXED_DELAY != 0) ?
    LGDLY'(FIXED_DELAY) : i_delay;

  assign restart = (dly != r_delay_q);

  assign path = (dly == '0) ? DP_LIVE :
    (dly == LGDLY'(1)) ? DP_REG : DP_MEM;

  always_comb begin
    wraddr_d  = wraddr_q + LGDLY'(i_ce);
    // RAM reads on the strobe, one sample ahead of use
    rdaddr_d  = wraddr_d + LGDLY'(1) - dly;
    r_delay_d = dly;

    cnt_d = cnt_q;
    if (restart)
      cnt_d = {{LGDLY{1'b0}}, i_ce};
    else if (i_ce && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CW'(1);

    primed_d = primed_q;
    if (restart)
      primed_d = 1'b0;
    else if (i_ce)
      primed_d = (cnt_d >= ({1'b0, dly} + CW'(1)));

    word_d = i_ce ? i_word : word_q;

    sel_data = rd_data;
    unique case (path)
      DP_LIVE: sel_data = i_word;
      DP_REG:  sel_data = word_q;
      default: sel_data = rd_data;
    endcase

    delayed_d = delayed_q;
    if (i_ce) begin
      if (OPT_ZERO_FILL != 0 && !primed_d)
        delayed_d = '0;
      else
        delayed_d = sel_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wraddr_q  <= '0;
      rdaddr_q  <= '0;
      r_delay_q <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      delayed_q <= '0;
      primed_q  <= 1'b0;
    end else begin
      wraddr_q  <= wraddr_d;
      rdaddr_q  <= rdaddr_d;
      r_delay_q <= r_delay_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      delayed_q <= delayed_d;
      primed_q  <= primed_d;
    end
  end

  sdpram_w #(
    .AW(LGDLY),
    .DW(W)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (i_ce),
    .i_waddr(wraddr_q),
    .i_wdata(i_word),
    .i_re   (i_ce),
    .i_raddr(rdaddr_q),
    .o_rdata(rd_data)
  );

  assign o_word    = word_q;
  assign o_delayed = delayed_q;
  assign o_primed  = primed_q;

endmodule

// File: tb/tb_delaymc.sv
// Directed bench for delaymc: priming, bypass paths,
// sparse strobes, wrap, delay change, async reset.
module tb_delaymc;

  localparam int LGDLY = 4;
  localparam int DW    = 12;
  localparam int NCH   = 2;
  localparam int W     = NCH * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LGDLY-1:0] dly;
  logic             ce;
  logic [W-1:0]     word;
  logic [W-1:0]     o_word;
  logic [W-1:0]     o_delayed;
  logic             o_primed;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ew, ed;
  logic         ep;

  always #5 clk = ~clk;

  delaymc #(
    .LGDLY(LGDLY),
    .DW(DW),
    .NCH(NCH),
    .FIXED_DELAY(0),
    .OPT_ZERO_FILL(1)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_delay  (dly),
    .i_ce     (ce),
    .i_word   (word),
    .o_word   (o_word),
    .o_delayed(o_delayed),
    .o_primed (o_primed)
  );

  function automatic logic [W-1:0] mk(input int n);
    logic [DW-1:0] l0, l1;
    l0 = DW'(n);
    l1 = DW'(n + 100);
    return {l1, l0};
  endfunction

  task automatic chk(input string tag, input int n,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d obs=%h exp=%h",
             tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ce    = 1'b0;
    #2;
    chk("rst_word", -1, o_word, '0);
    chk("rst_dly", -1, o_delayed, '0);
    chk("rst_prm", -1, W'(o_primed), '0);
    ew = '0;
    ed = '0;
    ep = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // n0: sample index of the most recent restart
  task automatic run(input int d, input int nf,
                     input int nl, input int n0,
                     input int gap);
    for (int n = nf; n <= nl; n++) begin
      for (int g = 1; g < gap; g++) begin
        ce   = 1'b0;
        word = W'($urandom);
        tick();
        chk("hold_word", n, o_word, ew);
        chk("hold_dly", n, o_delayed, ed);
        chk("hold_prm", n, W'(o_primed), W'(ep));
      end
      ce   = 1'b1;
      word = mk(n);
      tick();
      ew = mk(n);
      ep = ((n - n0) >= d);
      ed = ep ? mk(n - d) : '0;
      chk("word", n, o_word, ew);
      chk("prm", n, W'(o_primed), W'(ep));
      chk("dly", n, o_delayed, ed);
    end
    ce = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    word  = '0;
    dly   = 4'd3;
    ew    = '0;
    ed    = '0;
    ep    = 1'b0;

    // D=3, continuous strobe
    do_reset();
    run(3, 0, 11, 0, 1);

    // D=0 live bypass
    dly = 4'd0;
    do_reset();
    run(0, 0, 7, 0, 1);

    // D=1 register bypass
    dly = 4'd1;
    do_reset();
    run(1, 0, 7, 0, 1);

    // D=5, strobe every third clock
    dly = 4'd5;
    do_reset();
    run(5, 0, 11, 0, 3);

    // D=15, across pointer wrap
    dly = 4'd15;
    do_reset();
    run(15, 0, 39, 0, 1);

    // D=4 then switch to D=2 mid-stream
    dly = 4'd4;
    do_reset();
    run(4, 0, 9, 0, 1);
    dly = 4'd2;
    run(2, 10, 17, 10, 1);

    // async reset mid-stream, then refill
    dly = 4'd3;
    do_reset();
    run(3, 0, 5, 0, 1);
    do_reset();
    run(3, 50, 59, 50, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
